// File: rtl/spi_mem_slave.sv
// SPI responder with a small register file: decodes op/addr/data frames from cs/sclk/mosi,
// returns read data on miso, flags out-of-range addresses on err and pulses done per frame.
module spi_mem_slave #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic sclk,
    input  logic mosi,
    output logic miso,
    output logic done,
    output logic err
);

    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OP    = 3'd1,
        ADDR  = 3'd2,
        WDATA = 3'd3,
        RDATA = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_prev;
    logic                   sclk_prev;

    logic cs_s;
    logic sclk_s;
    logic mosi_s;
    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;

    logic              op_q,    op_n;
    logic [ADDR_W-1:0] addr_q,  addr_n;
    logic [DATA_W-1:0] data_q,  data_n;
    logic [DATA_W-1:0] rd_q,    rd_n;
    logic [CNT_W-1:0]  cnt_q,   cnt_n;
    logic              miso_q,  miso_n;
    logic              done_q,  done_n;
    logic              err_q,   err_n;
    logic              mem_we;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH);
    endfunction

    // Input synchronisers; cs idles high so reset it high to avoid a false frame start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_prev   <= cs_sync[SYNC_STAGES-1];
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign sclk_fall = sclk_prev & ~sclk_s;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            op_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            miso_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            addr_q <= addr_n;
            data_q <= data_n;
            rd_q   <= rd_n;
            cnt_q  <= cnt_n;
            miso_q <= miso_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    // Register file, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[IDX_W'(addr_q)] <= data_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        op_n    = op_q;
        addr_n  = addr_q;
        data_n  = data_q;
        rd_n    = rd_q;
        cnt_n   = cnt_q;
        miso_n  = 1'b0;
        done_n  = 1'b0;
        err_n   = err_q;
        mem_we  = 1'b0;

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n = OP;
                    err_n   = 1'b0;
                    cnt_n   = '0;
                    op_n    = 1'b0;
                    addr_n  = '0;
                    data_n  = '0;
                    rd_n    = '0;
                end
            end

            OP: begin
                if (cs_rise) begin
                    state_n = IDLE;
                end else if (sclk_rise) begin
                    op_n    = mosi_s;
                    state_n = ADDR;
                end
            end

            ADDR: begin
                if (cs_rise) begin
                    state_n = IDLE;
                end else if (sclk_rise) begin
                    addr_n = {addr_q[ADDR_W-2:0], mosi_s};
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        cnt_n = '0;
                        if (op_q) begin
                            state_n = WDATA;
                        end else begin
                            state_n = RDATA;
                            rd_n    = in_range(addr_n) ? mem[IDX_W'(addr_n)] : '0;
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end

            WDATA: begin
                if (cs_rise) begin
                    state_n = IDLE;
                end else if (sclk_rise) begin
                    data_n = {data_q[DATA_W-2:0], mosi_s};
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_n = FIN;
                        done_n  = 1'b1;
                        err_n   = ~in_range(addr_q);
                        mem_we  = in_range(addr_q);
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end

            RDATA: begin
                if (cs_rise) begin
                    state_n = IDLE;
                end else begin
                    miso_n = miso_q;
                    // Shift out on falls so the master sees a stable bit at its next rise
                    if (sclk_fall) begin
                        miso_n = rd_q[DATA_W-1];
                        rd_n   = {rd_q[DATA_W-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_n = FIN;
                            done_n  = 1'b1;
                            err_n   = ~in_range(addr_q);
                            miso_n  = 1'b0;
                        end else begin
                            cnt_n = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end

            FIN: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign miso = miso_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_spi_mem_slave.sv
// Self-checking bench for spi_mem_slave: a master model drives frames, a reference memory
// predicts read data into a scoreboard queue that is checked as each read frame completes.
module tb_spi_mem_slave;

    logic clk = 1'b0;
    logic rst;
    logic cs;
    logic sclk;
    logic mosi;
    logic miso;
    logic done;
    logic err;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    logic [7:0] ref_mem [32];
    logic [7:0] exp_q [$];

    spi_mem_slave #(
        .ADDR_W(8), .DATA_W(8), .DEPTH(32), .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .sclk (sclk),
        .mosi (mosi),
        .miso (miso),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    // Each clk cycle with done high counts once, so one frame must add exactly 1
    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode-0 master: nbits sclk cycles of 16 clk each; miso sampled just before rises 9..16
    task automatic spi_frame(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                             input int nbits, input bit end_cs, input int gap,
                             output logic [7:0] rx);
        logic [16:0] frame;
        frame = {wr, addr, data};
        rx    = '0;
        cs    = 1'b0;
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            mosi = frame[16-i];
            tick(8);
            if (i >= 9) rx = {rx[6:0], miso};
            sclk = 1'b1;
            tick(8);
            sclk = 1'b0;
        end
        if (end_cs) begin
            tick(8);
            cs = 1'b1;
            tick(gap);
        end
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input int gap);
        int         d0;
        logic [7:0] rx;
        d0 = done_cnt;
        spi_frame(1'b1, addr, data, 17, 1'b1, gap, rx);
        check("wr_done", 32'(done_cnt - d0), 32'd1);
        check("wr_err", 32'(err), (addr >= 8'd32) ? 32'd1 : 32'd0);
        if (addr < 8'd32) ref_mem[addr[4:0]] = data;
    endtask

    task automatic do_read(input logic [7:0] addr, input int gap);
        int         d0;
        logic [7:0] rx;
        logic [7:0] exp;
        exp_q.push_back((addr < 8'd32) ? ref_mem[addr[4:0]] : 8'h00);
        d0 = done_cnt;
        spi_frame(1'b0, addr, 8'hA5, 17, 1'b1, gap, rx);
        check("rd_done", 32'(done_cnt - d0), 32'd1);
        check("rd_err", 32'(err), (addr >= 8'd32) ? 32'd1 : 32'd0);
        if (exp_q.size() == 0) begin
            check("rd_queue_empty", 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check("rd_data", 32'(rx), 32'(exp));
        end
    endtask

    initial begin
        int         d0;
        logic [7:0] rx;

        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        rst  = 1'b0;
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        tick(4);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick(4);

        // Whole memory reads back as zero after reset
        for (int a = 0; a < 32; a++) do_read(8'(a), 4);

        // Basic write then read
        do_write(8'd25, 8'd25, 4);
        do_read(8'd25, 4);

        // Out-of-range write and read, then err clears on an in-range frame
        do_write(8'd40, 8'hAA, 4);
        do_read(8'd40, 4);
        do_read(8'd31, 4);
        do_read(8'd8, 4);

        // cs raised after 5 sclk cycles aborts the write
        d0 = done_cnt;
        spi_frame(1'b1, 8'd3, 8'h77, 5, 1'b1, 4, rx);
        check("abort_done", 32'(done_cnt - d0), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        do_read(8'd3, 4);

        // Back-to-back frames with minimum cs-high gap
        do_write(8'h00, 8'hFF, 3);
        do_write(8'h1F, 8'h5A, 3);
        do_read(8'h00, 3);
        do_read(8'h1F, 3);

        // Reset mid RDATA while miso is driving a 1 (bit 4 of 0x19)
        d0 = done_cnt;
        spi_frame(1'b0, 8'd25, 8'h00, 12, 1'b0, 0, rx);
        tick(6);
        check("mid_rd_miso", 32'(miso), 32'd1);
        rst = 1'b0;
        cs  = 1'b1;
        #1;
        check("rst_async_miso", 32'(miso), 32'd0);
        check("rst_mid_done", 32'(done_cnt - d0), 32'd0);
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        tick(3);
        rst = 1'b1;
        tick(4);
        check("rst_mid_err", 32'(err), 32'd0);
        do_read(8'd25, 4);
        do_write(8'd25, 8'h3C, 4);
        do_read(8'd25, 4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
